// File: rtl/ym3438_pg_pkg.sv
// ym3438_pg_pkg: shared constants and block/detune frequency helper for the phase generator
package ym3438_pg_pkg;
  localparam int PHASE_W_DEF = 20;
  localparam logic [3:0] MULTI_HALF = 4'd0;
  // Evaluated in 64 bits; the caller truncates to its own frequency width, which gives the required modulo wrap.
  function automatic logic [63:0] pg_freq(input logic [63:0] fnum, input logic [7:0] block, input logic dt_sign, input logic [63:0] dt);
    pg_freq = ((fnum << block) >> 1) + (dt_sign ? -dt : dt);
  endfunction
endpackage

// File: rtl/ym3438_pg_inc.sv
// ym3438_pg_inc: S1 block/detune frequency and S2 MULTI scaling, both registered on i_ce
// Ports: i_clk/i_rst_n/i_ce control; i_slot..i_key_reset per-slot inputs; o_inc/o_slot/o_key_reset/o_valid S2 outputs.
module ym3438_pg_inc
  import ym3438_pg_pkg::*;
#(
  parameter int FNUM_W  = 11,
  parameter int BLOCK_W = 3,
  parameter int DT_W    = 5,
  parameter int PHASE_W = PHASE_W_DEF,
  parameter int SW      = 5
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_ce,
  input  logic [SW-1:0]      i_slot,
  input  logic [FNUM_W-1:0]  i_fnum,
  input  logic [BLOCK_W-1:0] i_block,
  input  logic               i_dt_sign,
  input  logic [DT_W-1:0]    i_dt_value,
  input  logic [3:0]         i_multi,
  input  logic               i_key_reset,
  output logic [PHASE_W-1:0] o_inc,
  output logic [SW-1:0]      o_slot,
  output logic               o_key_reset,
  output logic               o_valid
);
  localparam int FW = FNUM_W + 2**BLOCK_W - 1;
  logic [FW-1:0] w_fd, r_fd;
  logic [FW+3:0] w_full;
  logic [3:0] r_multi;
  logic [SW-1:0] r_slot;
  logic r_kr, r_valid;
  assign w_fd = FW'(pg_freq(64'(i_fnum), 8'(i_block), i_dt_sign, 64'(i_dt_value)));
  assign w_full = (r_multi == MULTI_HALF) ? (FW+4)'(r_fd >> 1) : (FW+4)'(r_fd) * (FW+4)'(r_multi);
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_fd <= '0;
      r_multi <= '0;
      r_slot <= '0;
      r_kr <= 1'b0;
      r_valid <= 1'b0;
      o_inc <= '0;
      o_slot <= '0;
      o_key_reset <= 1'b0;
      o_valid <= 1'b0;
    end else if (i_ce) begin
      r_fd <= w_fd;
      r_multi <= i_multi;
      r_slot <= i_slot;
      r_kr <= i_key_reset;
      r_valid <= 1'b1;
      o_inc <= r_kr ? '0 : PHASE_W'(w_full);
      o_slot <= r_slot;
      o_key_reset <= r_kr;
      o_valid <= r_valid;
    end
endmodule

// File: rtl/ym3438_pg_multislot.sv
// ym3438_pg_multislot: time-multiplexed phase generator with slot counter, phase store, accumulate stage and readback
// Ports: MCLK/IC/ce control; slot_o/sync_o slot being sampled; fnum..freeze per-slot inputs;
//        pg_out/pg_slot/pg_valid accumulated phase MSBs; rd_slot/rd_phase random-access phase readback.
module ym3438_pg_multislot
  import ym3438_pg_pkg::*;
#(
  parameter int SLOTS   = 24,
  parameter int FNUM_W  = 11,
  parameter int BLOCK_W = 3,
  parameter int DT_W    = 5,
  parameter int PHASE_W = PHASE_W_DEF,
  parameter int OUT_W   = 10,
  localparam int SW     = $clog2(SLOTS)
) (
  input  logic               MCLK,
  input  logic               IC,
  input  logic               ce,
  output logic [SW-1:0]      slot_o,
  output logic               sync_o,
  input  logic [FNUM_W-1:0]  fnum,
  input  logic [BLOCK_W-1:0] block,
  input  logic               dt_sign,
  input  logic [DT_W-1:0]    dt_value,
  input  logic [3:0]         multi,
  input  logic               key_reset,
  input  logic               freeze,
  output logic [OUT_W-1:0]   pg_out,
  output logic [SW-1:0]      pg_slot,
  output logic               pg_valid,
  input  logic [SW-1:0]      rd_slot,
  output logic [PHASE_W-1:0] rd_phase
);
  localparam logic [SW-1:0] L_LAST = SW'(SLOTS - 1);
  localparam logic [SW:0] L_SLOTS = (SW+1)'(SLOTS);
  logic [SW-1:0] r_slot, w_s2_slot;
  logic [PHASE_W-1:0] r_mem [SLOTS];
  logic [PHASE_W-1:0] w_inc, w_old, w_new;
  logic w_s2_kr, w_s2_v, w_wr, w_rd_in;
  ym3438_pg_inc #(
    .FNUM_W(FNUM_W), .BLOCK_W(BLOCK_W), .DT_W(DT_W), .PHASE_W(PHASE_W), .SW(SW)
  ) u_inc (
    .i_clk(MCLK), .i_rst_n(IC), .i_ce(ce), .i_slot(r_slot), .i_fnum(fnum), .i_block(block),
    .i_dt_sign(dt_sign), .i_dt_value(dt_value), .i_multi(multi), .i_key_reset(key_reset),
    .o_inc(w_inc), .o_slot(w_s2_slot), .o_key_reset(w_s2_kr), .o_valid(w_s2_v)
  );
  assign slot_o = r_slot;
  assign sync_o = r_slot == '0;
  assign w_old = r_mem[w_s2_slot];
  assign w_new = (w_s2_kr ? '0 : w_old) + w_inc;
  // key-on must land even while frozen, otherwise the slot would never restart from zero
  assign w_wr = ce && w_s2_v && (!freeze || w_s2_kr);
  assign w_rd_in = {1'b0, rd_slot} < L_SLOTS;
  always_ff @(posedge MCLK or negedge IC)
    if (!IC) begin
      r_slot <= '0;
      pg_out <= '0;
      pg_slot <= '0;
      pg_valid <= 1'b0;
      rd_phase <= '0;
      for (int i = 0; i < SLOTS; i++) r_mem[i] <= '0;
    end else begin
      if (ce) begin
        r_slot <= (r_slot == L_LAST) ? '0 : r_slot + SW'(1);
        pg_valid <= w_s2_v;
        if (w_s2_v) begin
          pg_out <= w_wr ? w_new[PHASE_W-1 -: OUT_W] : w_old[PHASE_W-1 -: OUT_W];
          pg_slot <= w_s2_slot;
        end
      end
      if (w_wr) r_mem[w_s2_slot] <= w_new;
      rd_phase <= !w_rd_in ? '0 : (w_wr && w_s2_slot == rd_slot) ? w_new : r_mem[rd_slot];
    end
endmodule
